bd_encoder: RTL

- Downstream-direction counterpart of the BD output-funnel decoder.
- Accepts a (leaf_code, payload) pair from FPGA-side logic and serialises the payload into one or more chunks.
- Prefixes each chunk with the leaf's horn route and presents the 21-bit words to the BD input channel.
- Sits between the FPGA core router and the BD input serialiser.

---
 rtl/bd_encoder_if.sv | 23 ++
 rtl/bd_encoder.sv | 119 +++++++++++
 2 files changed

// File: rtl/bd_encoder_if.sv
// bd_encoder handshake bundle: FPGA-side input word and BD-side output word.
// The encoder takes the slave view; the driving logic takes the master view.
interface bd_encoder_if;
  logic        in_v;
  logic        in_a;
  logic [3:0]  in_leaf_code;
  logic [63:0] in_payload;
  logic        out_v;
  logic        out_a;
  logic [20:0] out_d;
  logic        invalid_code;
  logic        busy;

  modport master (
    output in_v, in_leaf_code, in_payload, out_a,
    input  in_a, out_v, out_d, invalid_code, busy
  );

  modport slave (
    input  in_v, in_leaf_code, in_payload, out_a,
    output in_a, out_v, out_d, invalid_code, busy
  );
endinterface

// File: rtl/bd_encoder.sv
// bd_encoder: splits a leaf payload into route-prefixed 21-bit BD words.
// Single-chunk leaves stream one word per cycle through the last-chunk reload.
module bd_encoder (
  input logic         clk,
  input logic         reset_n,
  bd_encoder_if.slave bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_n;
  logic [3:0]  code_q;
  logic [63:0] payload_q;
  logic [1:0]  cnt_q, cnt_n;
  logic        inv_q, inv_n;
  logic        load;
  logic        acc;
  logic        in_ok;
  logic        last;

  logic [5:0]  route;
  logic [4:0]  cw;
  logic [2:0]  ser;
  logic [5:0]  sh;
  logic [20:0] chunk;
  logic [20:0] mask;
  logic [20:0] word;

  assign in_ok = (bus.in_leaf_code < 4'd10);

  always_comb begin
    route = 6'd0;
    cw    = 5'd20;
    ser   = 3'd1;
    case (code_q)
      4'd1:    begin route = 6'b001000; cw = 5'd17; ser = 3'd2; end
      4'd2:    begin route = 6'b001001; cw = 5'd17; ser = 3'd2; end
      4'd3:    begin route = 6'b001010; cw = 5'd17; ser = 3'd2; end
      4'd4:    begin route = 6'b001011; cw = 5'd17; ser = 3'd2; end
      4'd5:    begin route = 6'b001100; cw = 5'd17; ser = 3'd1; end
      4'd6:    begin route = 6'b011010; cw = 5'd16; ser = 3'd4; end
      4'd7:    begin route = 6'b110110; cw = 5'd15; ser = 3'd1; end
      4'd8:    begin route = 6'b110111; cw = 5'd15; ser = 3'd1; end
      4'd9:    begin route = 6'b001110; cw = 5'd17; ser = 3'd1; end
      default: begin route = 6'd0;      cw = 5'd20; ser = 3'd1; end
    endcase
  end

  assign sh    = 6'(cnt_q) * 6'(cw);
  assign chunk = 21'(payload_q >> sh);
  assign mask  = (21'd1 << cw) - 21'd1;
  assign word  = (21'(route) << cw) | (chunk & mask);
  assign last  = (cnt_q == 2'(ser - 3'd1));

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    inv_n   = 1'b0;
    load    = 1'b0;
    acc     = 1'b0;
    case (state_q)
      IDLE: begin
        acc = 1'b1;
        if (bus.in_v) begin
          if (in_ok) begin
            load    = 1'b1;
            state_n = SEND;
          end else begin
            inv_n = 1'b1;
          end
        end
      end
      SEND: begin
        if (bus.out_a) begin
          if (last) begin
            acc = 1'b1;
            if (bus.in_v && in_ok) begin
              load = 1'b1;
            end else begin
              state_n = IDLE;
              inv_n   = bus.in_v;
            end
          end else begin
            cnt_n = cnt_q + 2'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      code_q    <= 4'd0;
      payload_q <= 64'd0;
      cnt_q     <= 2'd0;
      inv_q     <= 1'b0;
    end else begin
      state_q <= state_n;
      inv_q   <= inv_n;
      if (load) begin
        code_q    <= bus.in_leaf_code;
        payload_q <= bus.in_payload;
        cnt_q     <= 2'd0;
      end else begin
        cnt_q <= cnt_n;
      end
    end
  end

  // acc is gated so upstream sees no accept while held in reset
  assign bus.in_a         = reset_n & acc;
  assign bus.busy         = (state_q == SEND);
  assign bus.out_v        = (state_q == SEND);
  assign bus.out_d        = (state_q == SEND) ? word : 21'd0;
  assign bus.invalid_code = inv_q;

endmodule
